// File: rtl/acc_adder_pipe.sv
// Two-stage pipelined adder/subtractor with an internal accumulator, signed/unsigned
// modes, optional saturation, a sticky overflow flag and a global stall enable.
module acc_adder_pipe #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic             In_valid,
   input  logic [1:0]       Mode,
   input  logic             Signed,
   input  logic             Sat,
   input  logic             Clr_acc,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
   output logic             Out_valid,
   output logic             Overflow,
   output logic             Ovf_sticky,
   output logic [WIDTH-1:0] Acc
);

   logic [WIDTH-1:0] a_p1, b_p1;
   logic [1:0]       mode_p1;
   logic             sgn_p1, sat_p1, vld_p1;

   logic [WIDTH-1:0]        x_op;
   logic [WIDTH:0]          res_u;
   logic signed [WIDTH:0]   xs, bs, res_s;
   logic [WIDTH-1:0]        wrapped, sum_nxt;
   logic                    ovf_nxt;

   // Signed overflow shows up as the two top bits of the sign-extended result disagreeing.
   function automatic logic overflow(input logic [WIDTH:0] ru, input logic signed [WIDTH:0] rs,
                                     input logic sgn);
      logic o;
      if (sgn) o = rs[WIDTH] ^ rs[WIDTH-1];
      else     o = ru[WIDTH];
      return o;
   endfunction

   // On signed overflow the true result sign equals the extended sign bit.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wr, input logic ovf,
                                                 input logic sat, input logic sgn,
                                                 input logic sub, input logic neg);
      logic [WIDTH-1:0] r;
      r = wr;
      if (ovf && sat) begin
         if (sgn)      r = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         else if (sub) r = '0;
         else          r = '1;
      end
      return r;
   endfunction

   always_comb begin
      x_op = a_p1;
      if (mode_p1[1]) x_op = Clr_acc ? '0 : Acc;
      xs    = {x_op[WIDTH-1], x_op};
      bs    = {b_p1[WIDTH-1], b_p1};
      res_u = mode_p1[0] ? ({1'b0, x_op} - {1'b0, b_p1}) : ({1'b0, x_op} + {1'b0, b_p1});
      res_s = mode_p1[0] ? (xs - bs) : (xs + bs);
      wrapped = sgn_p1 ? res_s[WIDTH-1:0] : res_u[WIDTH-1:0];
      ovf_nxt = overflow(res_u, res_s, sgn_p1);
      sum_nxt = saturate(wrapped, ovf_nxt, sat_p1, sgn_p1, mode_p1[0], res_s[WIDTH]);
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         a_p1       <= '0;
         b_p1       <= '0;
         mode_p1    <= '0;
         sgn_p1     <= 1'b0;
         sat_p1     <= 1'b0;
         vld_p1     <= 1'b0;
         Sum        <= '0;
         Overflow   <= 1'b0;
         Out_valid  <= 1'b0;
         Ovf_sticky <= 1'b0;
         Acc        <= '0;
      end else if (En) begin
         // Stage 1: operand capture
         a_p1    <= A;
         b_p1    <= B;
         mode_p1 <= Mode;
         sgn_p1  <= Signed;
         sat_p1  <= Sat;
         vld_p1  <= In_valid;
         // Stage 2: result, accumulator and sticky flag
         Out_valid <= vld_p1;
         if (vld_p1) begin
            Sum      <= sum_nxt;
            Overflow <= ovf_nxt;
         end
         if (vld_p1 && mode_p1[1]) Acc <= sum_nxt;
         else if (Clr_acc)         Acc <= '0;
         if (vld_p1 && ovf_nxt)    Ovf_sticky <= 1'b1;
         else if (Clr_acc)         Ovf_sticky <= 1'b0;
      end
   end

endmodule
